// File: rtl/fft32_pkg.sv
// Shared constants and types for the 32-point MDC FFT controller.
package fft32_pkg;
  localparam int N_PTS = 32;
  localparam int CNT_W = 6;
  localparam int N_STG = 5;

  // Commutator delays for stages 1..4, index 0 = stage 1.
  localparam logic [3:0][3:0] STG_DLY = {4'd1, 4'd2, 4'd4, 4'd8};

  // Stage start offset: running sum of commutator delay plus one butterfly cycle.
  function automatic logic [5:0] stg_off(input int k);
    logic [5:0] o;
    o = '0;
    for (int i = 0; i < k; i++) o = o + 6'(STG_DLY[i]) + 6'd1;
    return o;
  endfunction

  localparam logic [N_STG-1:0][5:0] STG_OFF =
    {stg_off(4), stg_off(3), stg_off(2), stg_off(1), stg_off(0)};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
endpackage

// File: rtl/fft32_stage_dec.sv
// Per-stage window decode: active while the master count is inside this stage's 16-pair window.
module fft32_stage_dec #(
  parameter int CNT_W  = 6,
  parameter int LEN    = 16,
  parameter int ADDR_W = 4
) (
  input  logic [CNT_W-1:0]  cnt,
  input  logic [CNT_W-1:0]  off,
  input  logic              en,
  output logic              active,
  output logic [ADDR_W-1:0] loc
);
  logic [CNT_W-1:0] diff;

  assign diff   = cnt - off;
  assign active = en && (cnt >= off) && (diff < CNT_W'(LEN));
  assign loc    = active ? diff[ADDR_W-1:0] : '0;
endmodule

// File: rtl/fft32_mdc_ctrl.sv
// Frame controller for a 32-point radix-2 MDC FFT: master count, FSM and per-stage twiddle/commutator decode.
module fft32_mdc_ctrl #(
  parameter int N_PTS = fft32_pkg::N_PTS,
  parameter int CNT_W = fft32_pkg::CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       pipe_en,
  output logic [3:0] rom_16_counter,
  output logic [2:0] rom_8_counter,
  output logic [1:0] rom_4_counter,
  output logic [0:0] rom_2_counter,
  output logic [3:0] sw_sel,
  output logic       out_valid,
  output logic       frame_done
);
  import fft32_pkg::*;

  localparam int HALF = N_PTS / 2;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_STG-1:0] act;
  logic [3:0]       loc_last;
  logic             run, last;

  assign run  = (state != IDLE);
  // Last output pair: final slot of the stage-5 window.
  assign last = act[N_STG-1] && (loc_last == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    in_ready   = 1'b0;
    pipe_en    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        pipe_en  = in_valid;
        if (in_valid) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(HALF - 1)) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        pipe_en = 1'b1;
        if (last) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stage k address width is 5-k bits; its commutator select is the address MSB.
  for (genvar g = 0; g < N_STG; g++) begin : g_stg
    localparam int AW = (g < N_STG - 1) ? N_STG - 1 - g : 4;
    logic [AW-1:0] loc;

    fft32_stage_dec #(.CNT_W(CNT_W), .LEN(HALF), .ADDR_W(AW)) u_dec (
      .cnt    (cnt),
      .off    (CNT_W'(STG_OFF[g])),
      .en     (run),
      .active (act[g]),
      .loc    (loc)
    );

    if (g < N_STG - 1) begin : g_sw
      assign sw_sel[g] = loc[AW-1];
    end

    case (g)
      0:       begin : g_rom assign rom_16_counter = loc; end
      1:       begin : g_rom assign rom_8_counter  = loc; end
      2:       begin : g_rom assign rom_4_counter  = loc; end
      3:       begin : g_rom assign rom_2_counter  = loc; end
      default: begin : g_rom assign loc_last       = loc; end
    endcase
  end

  assign out_valid = pipe_en && act[N_STG-1];
endmodule

// File: tb/tb_fft32_mdc_ctrl.sv
// Directed bench for fft32_mdc_ctrl: full frames, input gaps, stray starts and mid-frame reset.
module tb_fft32_mdc_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, pipe_en, out_valid, frame_done;
  logic [3:0] rom_16_counter, sw_sel;
  logic [2:0] rom_8_counter;
  logic [1:0] rom_4_counter;
  logic [0:0] rom_2_counter;

  int n_chk = 0;
  int n_fail = 0;

  fft32_mdc_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .pipe_en        (pipe_en),
    .rom_16_counter (rom_16_counter),
    .rom_8_counter  (rom_8_counter),
    .rom_4_counter  (rom_4_counter),
    .rom_2_counter  (rom_2_counter),
    .sw_sel         (sw_sel),
    .out_valid      (out_valid),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stage window starting at off: 16 slots.
  function automatic bit win(input int c, input int off);
    return (c >= off) && (c <= off + 15);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, ".in_ready"},   32'(in_ready),       1);
    chk({tag, ".pipe_en"},    32'(pipe_en),        0);
    chk({tag, ".out_valid"},  32'(out_valid),      0);
    chk({tag, ".frame_done"}, 32'(frame_done),     0);
    chk({tag, ".rom16"},      32'(rom_16_counter), 0);
    chk({tag, ".rom8"},       32'(rom_8_counter),  0);
    chk({tag, ".rom4"},       32'(rom_4_counter),  0);
    chk({tag, ".rom2"},       32'(rom_2_counter),  0);
    chk({tag, ".sw_sel"},     32'(sw_sel),         0);
  endtask

  task automatic chk_cycle(input int c, input bit pe, input bit ir);
    int e16, e8, e4, e2, esw;
    e16 = win(c, 0)  ? c          : 0;
    e8  = win(c, 9)  ? (c - 9) % 8  : 0;
    e4  = win(c, 14) ? (c - 14) % 4 : 0;
    e2  = win(c, 17) ? (c - 17) % 2 : 0;
    // Stage 1 toggles every 8 active cycles, stage 2 every 4, stage 3 every 2, stage 4 every 1.
    esw = (win(c, 0)  ? (c / 8) % 2        : 0)
        | (win(c, 9)  ? ((c - 9) / 4) % 2  : 0) << 1
        | (win(c, 14) ? ((c - 14) / 2) % 2 : 0) << 2
        | (win(c, 17) ? (c - 17) % 2       : 0) << 3;
    chk($sformatf("rom16@%0d", c),      32'(rom_16_counter), e16);
    chk($sformatf("rom8@%0d", c),       32'(rom_8_counter),  e8);
    chk($sformatf("rom4@%0d", c),       32'(rom_4_counter),  e4);
    chk($sformatf("rom2@%0d", c),       32'(rom_2_counter),  e2);
    chk($sformatf("sw_sel@%0d", c),     32'(sw_sel),         esw);
    chk($sformatf("pipe_en@%0d", c),    32'(pipe_en),        32'(pe));
    chk($sformatf("in_ready@%0d", c),   32'(in_ready),       32'(ir));
    chk($sformatf("out_valid@%0d", c),  32'(out_valid),      32'(pe && win(c, 19)));
    chk($sformatf("frame_done@%0d", c), 32'(frame_done),     32'(pe && c == 34));
  endtask

  task automatic run_frame(input int gap_len, input bit glitch, input int abort_at);
    int c, gdone, nov, nfd;
    bit pe, done, aborted;
    c = 0; gdone = 0; nov = 0; nfd = 0; done = 0; aborted = 0;
    @(negedge clk); start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 100 && !done && !aborted; cyc++) begin
      start = glitch && (c == 7 || c == 25);
      if (c < 16) in_valid = !(c == 5 && gdone < gap_len);
      else        in_valid = 1'($urandom_range(0, 1));
      if (c == 5 && !in_valid) gdone++;
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1 chk_reset($sformatf("abort@%0d", c));
        @(negedge clk);
        #1 chk_reset("abort_hold");
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        aborted = 1;
      end else begin
        pe = (c < 16) ? in_valid : 1'b1;
        #1 chk_cycle(c, pe, c < 16);
        if (out_valid)  nov++;
        if (frame_done) nfd++;
        if (pe && c == 34) done = 1;
        if (pe) c++;
        @(negedge clk);
      end
    end
    if (!aborted) begin
      chk("frame_complete", 32'(done), 1);
      start = 1'b0; in_valid = 1'b0;
      #1 chk_reset("post_idle");
      chk("out_valid_count",  nov, 16);
      chk("frame_done_count", nfd, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #12 chk_reset("por");
    @(negedge clk); rst_n = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    #1 chk_reset("idle_ignores_valid");
    run_frame(0, 1'b0, -1);
    run_frame(3, 1'b0, -1);
    run_frame(0, 1'b1, -1);
    run_frame(0, 1'b0, 20);
    run_frame(0, 1'b0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fft32_mdc_ctrl.md
FFT32_MDC_CTRL -- requirements
Module: fft32_mdc_ctrl

Interface
REQ-001 Parameter: N_PTS, default 32, FFT length; only 32 is supported.
REQ-002 Parameter: CNT_W, default 6, master counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse that opens a frame; honoured only in IDLE.
REQ-006 in_valid  in  1  upper/lower input sample pair valid this cycle.
REQ-007 in_ready  out  1  controller accepts an input pair this cycle.
REQ-008 pipe_en  out  1  shift/enable for all MDC delay lines and butterflies.
REQ-009 rom_16_counter  out  4  stage-1 twiddle address, W32^n.
REQ-010 rom_8_counter  out  3  stage-2 twiddle address.
REQ-011 rom_4_counter  out  2  stage-3 twiddle address; drives the 4-entry twiddle ROM.
REQ-012 rom_2_counter  out  1  stage-4 twiddle address.
REQ-013 sw_sel  out  4  commutator selects; bit k-1 belongs to stage k (k=1..4).
REQ-014 out_valid  out  1  stage-5 output pair valid.
REQ-015 frame_done  out  1  one-cycle pulse on the last output pair.

Function
REQ-016 FSM states IDLE, RUN, FLUSH; encoding is free.
REQ-017 IDLE->RUN on start=1, with cnt cleared to 0; start in RUN or FLUSH is ignored.
REQ-018 RUN: cnt increments only when in_valid=1; pipe_en=in_valid; in_ready=1.
REQ-019 RUN->FLUSH on the accepted 16th pair (cnt 15->16); in_ready=0 from then on.
REQ-020 FLUSH: cnt increments every cycle; pipe_en=1; in_valid is ignored.
REQ-021 FLUSH->IDLE when cnt=34 with pipe_en=1; frame_done=1 in that cycle.
REQ-022 Stage offsets: OFF = {0, 9, 14, 17, 19} for stages 1..5.
- Each offset = previous offset + commutator delay (8, 4, 2, 1) + 1 butterfly cycle.
REQ-023 Local count: loc_k = cnt - OFF_k; stage k is active when 0 <= loc_k <= 15.
REQ-024 Twiddle addresses, valid while active: rom_16_counter=loc_1[3:0], rom_8_counter=loc_2[2:0], rom_4_counter=loc_3[1:0], rom_2_counter=loc_4[0].
REQ-025 sw_sel bit for stage k = bit (4-k) of loc_k while active (stage 1 bit3 ... stage 4 bit0); 0 otherwise.
REQ-026 Inactive stages drive their address and sw_sel bit to 0.
REQ-027 out_valid = pipe_en AND stage 5 active.
- Exactly 16 out_valid cycles per frame.
- First out_valid at cnt=19.
REQ-028 All outputs are registered, with zero extra latency relative to cnt; combinational decode from registered cnt/state is permitted.
REQ-029 Gaps in in_valid during RUN freeze cnt, all addresses and sw_sel, and hold pipe_en=0.
REQ-030 Unsigned arithmetic throughout; cnt never exceeds 34 and never wraps.

Reset
REQ-031 On rst_n=0, immediately:
- state=IDLE, cnt=0.
- All counter outputs and sw_sel = 0.
- in_ready=1, pipe_en=0, out_valid=0, frame_done=0.
REQ-032 Reset asserted mid-frame aborts the frame; no frame_done is issued.

Structure
REQ-033 Shared package fft32_pkg holds:
- N_PTS and CNT_W.
- The OFF table.
- The stage delay table {8,4,2,1}.
- The FSM state typedef.
REQ-034 One sub-module, fft32_stage_dec, instantiated per stage: cnt plus OFF_k in, active/loc_k out.

Verification
REQ-035 start, then in_valid=1 for 16 cycles:
- rom_16_counter 0..15 at cnt 0..15.
- rom_4_counter 0,1,2,3 repeating at cnt 14..29.
- out_valid at cnt 19..34; frame_done at cnt 34.
REQ-036 in_valid low for 3 cycles after pair 5: cnt holds at 5, pipe_en=0, addresses frozen; the sequence then resumes unchanged.
REQ-037 sw_sel check: stage 1 toggles every 8 active cycles, stage 2 every 4, stage 3 every 2, stage 4 every 1.
REQ-038 start pulsed at cnt=7 in RUN and at cnt=25 in FLUSH: no effect; the frame completes normally.
REQ-039 rst_n low at cnt=20: outputs reach their reset values without a clock edge, no frame_done occurs, and a new start runs a clean frame.
